anti_theft_fsm: RTL and testbench
=================================

# anti_theft_fsm

Central control FSM of the car alarm. Watches ignition and door switches, chooses which delay interval the countdown timer runs, issues the timer's load pulse, consumes the timer's `expired` flag, and drives the siren and status LED. The block sits directly upstream of the countdown timer, which loads the interval value chosen here, and downstream of the switch inputs and the timer's enable strobes.

## Interface
- No parameters; all widths are fixed.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ignition`  in  1  1 = key on; synchronous, debounced.
- `door_driver`  in  1  1 = driver door open; synchronous, debounced.
- `door_pass`  in  1  1 = passenger door open; synchronous, debounced.
- `reprogram`  in  1  1-cycle pulse from the parameter block; forces ARMED.
- `expired`  in  1  timer count is zero.
- `one_hz_enable`  in  1  timer blink strobe (level).
- `start_timer`  out  1  registered; timer loads while high.
- `interval`  out  2  registered selector into the parameter block:
  - 00 = T_ARM_DELAY
  - 01 = T_DRIVER_DELAY
  - 10 = T_PASSENGER_DELAY
  - 11 = T_ALARM_ON
- `siren`  out  1  registered; 1 = siren on.
- `status_indicator`  out  1  registered LED drive.
- `state_display`  out  3  current state code.

## Operation
- **State codes:**
  - ARMED = 0
  - TRIGGERED = 1
  - SOUND_ALARM = 2
  - IGN_ON = 3
  - IGN_OFF = 4
  - DOOR_OPEN = 5
  - ARM_DELAY = 6
  - Code 7 is illegal and recovers to ARMED on the next edge.
- **Priority, evaluated every cycle:** reprogram > ignition rule > door/expired rules.
- **ARMED:**
  - Any door open goes to TRIGGERED with a timer start.
  - interval = 01 if `door_driver` is open (driver wins if both open); otherwise 10.
  - `ignition` alone does not disarm.
- **TRIGGERED:**
  - `ignition` goes to IGN_ON.
  - A qualified `expired` goes to SOUND_ALARM with a timer start, interval = 11.
- **SOUND_ALARM:**
  - `ignition` goes to IGN_ON.
  - While any door is open, `start_timer` is held high with interval 11, reloading continuously.
  - A qualified `expired` goes to ARMED.
- **IGN_ON:** `!ignition` goes to IGN_OFF.
- **IGN_OFF:**
  - `ignition` goes to IGN_ON.
  - `door_driver` goes to DOOR_OPEN.
- **DOOR_OPEN:**
  - `ignition` goes to IGN_ON.
  - `!door_driver` goes to ARM_DELAY with a timer start, interval = 00.
- **ARM_DELAY:**
  - `ignition` goes to IGN_ON.
  - Any door open goes to DOOR_OPEN.
  - A qualified `expired` goes to ARMED.
- **reprogram:** from any state, go to ARMED. No timer start. `siren` = 0 on the next edge.
- **Expired qualification:** `expired` is honoured only when `start_timer` was low in both the current and the previous cycle. Implement this with a 1-bit `load_guard` register set whenever `start_timer` is high. This masks the stale `expired` the timer shows before its load completes.
- **Outputs by state:**
  - `siren` = 1 only in SOUND_ALARM.
  - `status_indicator` = `one_hz_enable` in ARMED, 1 in TRIGGERED and SOUND_ALARM, 0 in all other states.
- **interval:** holds its last value when no start is issued.

## Timing
- **Reset values:**
  - state = ARMED, `state_display` = 0
  - `start_timer` = 0, `interval` = 00
  - `siren` = 0, `status_indicator` = 0
  - `load_guard` = 0
- **Transitions:** a condition sampled at edge N takes effect at edge N, so the new `state_display` is visible from cycle N+1.
- **Timer start:** `start_timer` and `interval` are registered with the transition. Both are high/valid for exactly cycle N+1, one cycle, except the SOUND_ALARM door hold.
- **Earliest expiry:** the earliest qualified `expired` is in cycle N+3. A load of value 0 therefore expires 3 cycles after the triggering condition.
- **Output latency:** `siren` and `status_indicator` follow the state with 1-cycle latency. In ARMED, `status_indicator` is registered `one_hz_enable` and lags that input by one cycle.
- **Reset mid-countdown:** returns to ARMED with `start_timer` = 0. The timer is reset separately by the same `reset`.
- **Simultaneous events:**
  - `ignition` and `expired` together in TRIGGERED: IGN_ON wins.
  - `reprogram` and a door opening together in ARMED: stay ARMED, no start.

## Test plan
- **Reset then arm-cycle:**
  - Reset released, `door_pass` = 1 at cycle 5 → `state_display` = 1 at cycle 6, `start_timer` = 1 with `interval` = 10 at cycle 6 only, `status_indicator` = 1 at cycle 7.
- **Driver priority and expiry:**
  - Both doors open in ARMED → `interval` = 01.
  - Hold `expired` = 1 throughout: state stays 1 for 2 cycles after the start pulse, then goes to 2, with `siren` = 1 one cycle after state 2.
- **Siren hold:**
  - In SOUND_ALARM with `door_driver` held 10 cycles → `start_timer` = 1 with `interval` = 11 for those 10 cycles, `expired` ignored.
  - Close the door, `expired` = 1 → ARMED 2 cycles after `start_timer` falls, then `siren` = 0.
- **Disarm path:**
  - `ignition` in TRIGGERED → state 3.
  - `ignition` off → 4; `door_driver` on → 5; off → 6 with `interval` = 00.
  - Reopen door → 5; close → 6; `expired` → 0.
- **Override:**
  - `reprogram` pulse in SOUND_ALARM → state 0, `siren` 0 next cycle, no `start_timer`.
  - `ignition` with `expired` in TRIGGERED → state 3.
- **Async reset mid-SOUND_ALARM:**
  - All outputs at their reset values immediately, without waiting for a clock edge.
  - Force code 7 → ARMED next edge.

Source files
------------

// File: rtl/anti_theft_fsm_if.sv
// rtl/anti_theft_fsm_if.sv - link between the alarm control FSM and the countdown timer
interface anti_theft_fsm_if;
  logic       start_timer;
  logic [1:0] interval;
  logic       expired;
  logic       one_hz_enable;

  // FSM side: chooses the interval and loads the timer, watches expiry and blink strobe
  modport master (
    output start_timer,
    output interval,
    input  expired,
    input  one_hz_enable
  );

  // Timer side: loads on start_timer, reports expiry and the 1 Hz strobe
  modport slave (
    input  start_timer,
    input  interval,
    output expired,
    output one_hz_enable
  );
endinterface

// File: rtl/anti_theft_fsm.sv
// rtl/anti_theft_fsm.sv - car alarm control FSM driving the countdown timer, siren and LED
module anti_theft_fsm (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ignition,
  input  logic                     door_driver,
  input  logic                     door_pass,
  input  logic                     reprogram,
  anti_theft_fsm_if.master         tmr,
  output logic                     siren,
  output logic                     status_indicator,
  output logic [2:0]               state_display
);

  typedef enum logic [2:0] {
    ARMED       = 3'd0,
    TRIGGERED   = 3'd1,
    SOUND_ALARM = 3'd2,
    IGN_ON      = 3'd3,
    IGN_OFF     = 3'd4,
    DOOR_OPEN   = 3'd5,
    ARM_DELAY   = 3'd6,
    ILLEGAL     = 3'd7
  } state_t;

  localparam logic [1:0] SEL_ARM_DELAY  = 2'b00;
  localparam logic [1:0] SEL_DRIVER     = 2'b01;
  localparam logic [1:0] SEL_PASSENGER  = 2'b10;
  localparam logic [1:0] SEL_ALARM_ON   = 2'b11;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [1:0] interval_q, interval_d;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic       load_guard_q;
  logic       any_door;
  logic       expired_ok;

  assign any_door   = door_driver | door_pass;
  // The timer still shows the previous count for two cycles after a load, so
  // expiry is only believed once start_timer has been low for two cycles.
  assign expired_ok = tmr.expired & ~start_q & ~load_guard_q;

  // State and all registered outputs; reset clears everything immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ARMED;
      start_q      <= 1'b0;
      interval_q   <= SEL_ARM_DELAY;
      siren_q      <= 1'b0;
      led_q        <= 1'b0;
      load_guard_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      interval_q   <= interval_d;
      siren_q      <= siren_d;
      led_q        <= led_d;
      load_guard_q <= start_q;
    end
  end

  // Next state, timer load request and output drive from the current state
  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    interval_d = interval_q;
    siren_d    = (state_q == SOUND_ALARM);
    led_d      = 1'b0;

    case (state_q)
      ARMED:                 led_d = tmr.one_hz_enable;
      TRIGGERED, SOUND_ALARM: led_d = 1'b1;
      default:               led_d = 1'b0;
    endcase

    if (reprogram) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (any_door) begin
            state_d    = TRIGGERED;
            start_d    = 1'b1;
            interval_d = door_driver ? SEL_DRIVER : SEL_PASSENGER;
          end
        end
        TRIGGERED: begin
          if (ignition) begin
            state_d = IGN_ON;
          end else if (expired_ok) begin
            state_d    = SOUND_ALARM;
            start_d    = 1'b1;
            interval_d = SEL_ALARM_ON;
          end
        end
        SOUND_ALARM: begin
          if (ignition) begin
            state_d = IGN_ON;
          end else if (any_door) begin
            start_d    = 1'b1;
            interval_d = SEL_ALARM_ON;
          end else if (expired_ok) begin
            state_d = ARMED;
          end
        end
        IGN_ON: begin
          if (!ignition) state_d = IGN_OFF;
        end
        IGN_OFF: begin
          if (ignition) state_d = IGN_ON;
          else if (door_driver) state_d = DOOR_OPEN;
        end
        DOOR_OPEN: begin
          if (ignition) begin
            state_d = IGN_ON;
          end else if (!door_driver) begin
            state_d    = ARM_DELAY;
            start_d    = 1'b1;
            interval_d = SEL_ARM_DELAY;
          end
        end
        ARM_DELAY: begin
          if (ignition) state_d = IGN_ON;
          else if (any_door) state_d = DOOR_OPEN;
          else if (expired_ok) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  assign tmr.start_timer  = start_q;
  assign tmr.interval     = interval_q;
  assign siren            = siren_q;
  assign status_indicator = led_q;
  assign state_display    = state_q;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// tb/tb_anti_theft_fsm.sv - vector table, directed corner sequences and random model check
module tb_anti_theft_fsm;

  logic       clock;
  logic       reset;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic       siren;
  logic       status_indicator;
  logic [2:0] state_display;

  anti_theft_fsm_if tmr ();

  anti_theft_fsm dut (
    .clock            (clock),
    .reset            (reset),
    .ignition         (ignition),
    .door_driver      (door_driver),
    .door_pass        (door_pass),
    .reprogram        (reprogram),
    .tmr              (tmr),
    .siren            (siren),
    .status_indicator (status_indicator),
    .state_display    (state_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [5:0] in;   // {ignition, door_driver, door_pass, reprogram, expired, one_hz_enable}
    int         st;
    int         start;
    int         intv;
    int         siren;
    int         led;
  } vec_t;

  vec_t tbl [22];

  // reference model state (plain integers, spec rules)
  int m_st, m_start, m_prev, m_intv, m_siren, m_led;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic zero_inputs();
    ignition = 0; door_driver = 0; door_pass = 0; reprogram = 0;
    tmr.expired = 0; tmr.one_hz_enable = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic check_outs(input string tag, input int st, input int start, input int intv,
                            input int sir, input int led);
    chk({tag, " state"}, int'(state_display), st);
    chk({tag, " start_timer"}, int'(tmr.start_timer), start);
    chk({tag, " interval"}, int'(tmr.interval), intv);
    chk({tag, " siren"}, int'(siren), sir);
    chk({tag, " status"}, int'(status_indicator), led);
  endtask

  // from a quiet ARMED state, drive the alarm into SOUND_ALARM (start pulse cycle)
  task automatic go_sound_alarm();
    door_driver = 1;
    tick();
    door_driver = 0;
    tmr.expired = 1;
    tick();
    tick();
    tick();
    tmr.expired = 0;
  endtask

  task automatic model_reset();
    m_st = 0; m_start = 0; m_prev = 0; m_intv = 0; m_siren = 0; m_led = 0;
  endtask

  // Advance the model one clock edge using the rules of the alarm
  task automatic model_step(input bit ign, input bit dd, input bit dp, input bit rep,
                            input bit exp, input bit ohz);
    bit door_any;
    bit honoured;
    int ns, ns_start, ns_intv;
    door_any = dd || dp;
    honoured = exp && (m_start == 0) && (m_prev == 0);
    ns = m_st; ns_start = 0; ns_intv = m_intv;
    if (rep) ns = 0;
    else if (ign && (m_st inside {1, 2, 4, 5, 6})) ns = 3;
    else begin
      case (m_st)
        0: if (door_any) begin ns = 1; ns_start = 1; ns_intv = dd ? 1 : 2; end
        1: if (honoured) begin ns = 2; ns_start = 1; ns_intv = 3; end
        2: if (door_any) begin ns_start = 1; ns_intv = 3; end
           else if (honoured) ns = 0;
        3: if (!ign) ns = 4;
        4: if (dd) ns = 5;
        5: if (!dd) begin ns = 6; ns_start = 1; ns_intv = 0; end
        6: if (door_any) ns = 5;
           else if (honoured) ns = 0;
        default: ns = 0;
      endcase
    end
    m_siren = (m_st == 2) ? 1 : 0;
    m_led   = (m_st == 0) ? int'(ohz) : ((m_st == 1 || m_st == 2) ? 1 : 0);
    m_prev  = m_start;
    m_start = ns_start;
    m_intv  = ns_intv;
    m_st    = ns;
  endtask

  initial begin
    //                 ign dd dp rep exp ohz   st st iv sr led
    tbl[0]  = '{6'b000000, 0, 0, 0, 0, 0};
    tbl[1]  = '{6'b000001, 0, 0, 0, 0, 1};
    tbl[2]  = '{6'b001000, 1, 1, 2, 0, 0};
    tbl[3]  = '{6'b000010, 1, 0, 2, 0, 1};
    tbl[4]  = '{6'b000010, 1, 0, 2, 0, 1};
    tbl[5]  = '{6'b000010, 2, 1, 3, 0, 1};
    tbl[6]  = '{6'b000000, 2, 0, 3, 1, 1};
    tbl[7]  = '{6'b100000, 3, 0, 3, 1, 1};
    tbl[8]  = '{6'b100000, 3, 0, 3, 0, 0};
    tbl[9]  = '{6'b000000, 4, 0, 3, 0, 0};
    tbl[10] = '{6'b010000, 5, 0, 3, 0, 0};
    tbl[11] = '{6'b000000, 6, 1, 0, 0, 0};
    tbl[12] = '{6'b001000, 5, 0, 0, 0, 0};
    tbl[13] = '{6'b000000, 6, 1, 0, 0, 0};
    tbl[14] = '{6'b000010, 6, 0, 0, 0, 0};
    tbl[15] = '{6'b000010, 6, 0, 0, 0, 0};
    tbl[16] = '{6'b000010, 0, 0, 0, 0, 0};
    tbl[17] = '{6'b010100, 0, 0, 0, 0, 0};
    tbl[18] = '{6'b011001, 1, 1, 1, 0, 1};
    tbl[19] = '{6'b000000, 1, 0, 1, 0, 1};
    tbl[20] = '{6'b000000, 1, 0, 1, 0, 1};
    tbl[21] = '{6'b100010, 3, 0, 1, 0, 1};

    reset = 1;
    zero_inputs();
    repeat (2) @(negedge clock);
    check_outs("reset", 0, 0, 0, 0, 0);
    reset = 0;

    // vector table, one edge per record
    for (int i = 0; i < 22; i++) begin
      {ignition, door_driver, door_pass, reprogram, tmr.expired, tmr.one_hz_enable} = tbl[i].in;
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].start, tbl[i].intv,
                 tbl[i].siren, tbl[i].led);
    end

    // arm cycle: passenger door, single start pulse, LED a cycle later
    do_reset();
    repeat (4) tick();
    door_pass = 1;
    tick();
    chk("arm state", int'(state_display), 1);
    chk("arm start", int'(tmr.start_timer), 1);
    chk("arm interval", int'(tmr.interval), 2);
    door_pass = 0;
    tick();
    chk("arm start low", int'(tmr.start_timer), 0);
    chk("arm status", int'(status_indicator), 1);

    // siren hold: door open reloads continuously, expiry ignored
    do_reset();
    go_sound_alarm();
    chk("alarm state", int'(state_display), 2);
    chk("alarm interval", int'(tmr.interval), 3);
    door_driver = 1;
    tmr.expired = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("hold%0d start", k), int'(tmr.start_timer), 1);
      chk($sformatf("hold%0d state", k), int'(state_display), 2);
      chk($sformatf("hold%0d siren", k), int'(siren), 1);
    end
    door_driver = 0;
    tick();
    chk("hold fall start", int'(tmr.start_timer), 0);
    tick();
    chk("hold guard state", int'(state_display), 2);
    tick();
    chk("hold rearm state", int'(state_display), 0);
    chk("hold rearm siren", int'(siren), 1);
    tmr.expired = 0;
    tick();
    chk("hold siren off", int'(siren), 0);

    // reprogram overrides SOUND_ALARM without a timer start
    go_sound_alarm();
    reprogram = 1;
    tick();
    reprogram = 0;
    chk("reprog state", int'(state_display), 0);
    chk("reprog start", int'(tmr.start_timer), 0);
    tick();
    chk("reprog siren", int'(siren), 0);
    chk("reprog start2", int'(tmr.start_timer), 0);

    // asynchronous reset in the middle of SOUND_ALARM
    go_sound_alarm();
    tick();
    chk("pre-rst siren", int'(siren), 1);
    #2 reset = 1;
    #1;
    check_outs("async rst", 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 0;

    // random stimulus against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit r_ign, r_dd, r_dp, r_rep, r_exp, r_ohz;
      r_ign = ($urandom_range(0, 7) == 0);
      r_dd  = ($urandom_range(0, 3) == 0);
      r_dp  = ($urandom_range(0, 3) == 0);
      r_rep = ($urandom_range(0, 39) == 0);
      r_exp = ($urandom_range(0, 1) == 1);
      r_ohz = ($urandom_range(0, 1) == 1);
      if (m_st == 3 && $urandom_range(0, 1) == 1) r_ign = 1;
      {ignition, door_driver, door_pass, reprogram, tmr.expired, tmr.one_hz_enable} =
        {r_ign, r_dd, r_dp, r_rep, r_exp, r_ohz};
      model_step(r_ign, r_dd, r_dp, r_rep, r_exp, r_ohz);
      tick();
      check_outs($sformatf("rnd%0d", c), m_st, m_start, m_intv, m_siren, m_led);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
